// File: rtl/seg_display_mux_n_pkg.sv
// Shared seven-segment definitions: active-low hex font, dark pattern and decoder.
package display_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // {g,f,e,d,c,b,a}, active low, indexed by hex value
  localparam logic [6:0] SEG_FONT [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] i_val);
    return SEG_FONT[i_val];
  endfunction

endpackage

// File: rtl/seg_display_mux_n_scan_timer.sv
// Digit-slot timer: slot counter, scan index and the one-clock dead-time flag.
module seg_scan_timer #(
  parameter int  NUM_DIGITS  = 4,
  parameter int  REFRESH_DIV = 25000,
  localparam int IDX_W       = $clog2(NUM_DIGITS),
  localparam int SLOT_W      = $clog2(REFRESH_DIV)
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_dead
);

  logic [SLOT_W-1:0] r_slot;
  logic [IDX_W-1:0]  r_idx;
  logic              w_slot_wrap;
  logic              w_idx_wrap;

  assign w_slot_wrap = (r_slot == SLOT_W'(REFRESH_DIV - 1));
  assign w_idx_wrap  = (r_idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_slot <= '0;
      r_idx  <= '0;
    end else if (w_slot_wrap) begin
      r_slot <= '0;
      r_idx  <= w_idx_wrap ? '0 : r_idx + 1'b1;
    end else begin
      r_slot <= r_slot + 1'b1;
    end
  end

  assign o_idx  = r_idx;
  // First clock of each slot is kept dark so the previous digit's segments never bleed over
  assign o_dead = (r_slot == '0);

endmodule

// File: rtl/seg_display_mux_n.sv
// Time-multiplexed common-anode hex display driver with blanking, decimal points,
// leading-zero suppression, 8-level brightness PWM and anti-ghosting dead time.
module seg_display_mux_n
  import display_pkg::*;
#(
  parameter int  NUM_DIGITS  = 4,
  parameter int  REFRESH_DIV = 25000,
  localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [3:0]            din,
  input  logic [NUM_DIGITS-1:0] load_en,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  input  logic                  lzs,
  input  logic [2:0]            bright,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  logic [3:0]            r_digit [NUM_DIGITS];
  logic [2:0]            r_pwm;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;

  logic [IDX_W-1:0]      w_idx;
  logic                  w_dead;
  logic [NUM_DIGITS-1:0] w_supp;
  logic                  w_on;

  seg_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .o_idx   (w_idx),
    .o_dead  (w_dead)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (load_en[i]) r_digit[i] <= din;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_pwm <= '0;
    else          r_pwm <= r_pwm + 1'b1;
  end

  // Walk from the most significant digit down; blanked digits never end the zero run
  always_comb begin
    logic v_seen_nz;
    v_seen_nz = 1'b0;
    w_supp    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_supp[k] = lzs && (k != 0) && !v_seen_nz && (r_digit[k] == 4'h0);
      if ((r_digit[k] != 4'h0) && !blank_mask[k]) v_seen_nz = 1'b1;
    end
  end

  assign w_on = !w_dead && (r_pwm <= bright) && !blank_mask[w_idx] && !w_supp[w_idx];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_an  <= '1;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_on ? ~(NUM_DIGITS'(1) << w_idx) : '1;
      r_seg <= hex_to_seg(r_digit[w_idx]);
      r_dp  <= ~dp_mask[w_idx];
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_seg_display_mux_n.sv
// Self-checking bench for seg_display_mux_n against a cycle-level behavioural model.
module tb_seg_display_mux_n;

  localparam int N  = 4;
  localparam int RD = 4;

  logic         clock;
  logic         reset_n;
  logic [3:0]   din;
  logic [N-1:0] load_en, dp_mask, blank_mask;
  logic         lzs;
  logic [2:0]   bright;
  logic [N-1:0] an;
  logic [6:0]   seg;
  logic         dp;

  seg_display_mux_n #(.NUM_DIGITS(N), .REFRESH_DIV(RD)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .din        (din),
    .load_en    (load_en),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .lzs        (lzs),
    .bright     (bright),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int m_dig [N];
  int m_slot, m_idx, m_pwm;
  logic [N-1:0] e_an;
  logic [6:0]   e_seg;
  logic         e_dp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_dig[i] = 0;
    m_slot = 0; m_idx = 0; m_pwm = 0;
  endtask

  function automatic bit m_supp(input int k);
    if (!lzs || k == 0 || m_dig[k] != 0) return 1'b0;
    for (int j = k + 1; j < N; j++)
      if (m_dig[j] != 0 && !blank_mask[j]) return 1'b0;
    return 1'b1;
  endfunction

  // Predict what the next edge registers, advance the model, then compare after the edge.
  task automatic cycle();
    bit on;
    on    = (m_slot != 0) && (m_pwm <= int'(bright)) && !blank_mask[m_idx] && !m_supp(m_idx);
    e_an  = '1;
    if (on) e_an[m_idx] = 1'b0;
    e_seg = FONT[m_dig[m_idx]];
    e_dp  = ~dp_mask[m_idx];
    for (int i = 0; i < N; i++) if (load_en[i]) m_dig[i] = int'(din);
    m_pwm = (m_pwm + 1) % 8;
    if (m_slot == RD - 1) begin
      m_slot = 0;
      m_idx  = (m_idx + 1) % N;
    end else begin
      m_slot++;
    end
    @(posedge clock);
    @(negedge clock);
    chk("model_an", an, e_an);
    chk("model_seg", seg, e_seg);
    chk("model_dp", dp, e_dp);
  endtask

  task automatic quiet(input logic [2:0] b, input logic z);
    load_en = '0; dp_mask = '0; blank_mask = '0; lzs = z; bright = b; din = '0;
  endtask

  int cnt_e, cnt_d, cnt_b, cnt_7, cnt_f, cnt_lit, cnt_a2, cnt_a3, cnt_dp;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    quiet(3'd7, 1'b0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    chk("reset_an", an, 4'hF);
    chk("reset_seg", seg, 7'h7F);
    chk("reset_dp", dp, 1'b1);

    reset_n = 1'b1;
    cycle(); chk("rel_dead", an, 4'hF);
    cycle(); chk("rel_first_an", an, 4'hE);
    chk("rel_first_seg", seg, 7'h40);
    cycle(); cycle(); cycle(); chk("rel_slot0_idx1", an, 4'hF);
    cycle(); chk("rel_idx1_an", an, 4'hD);

    // Load digits 3..0 = 1, 2, A, F
    load_en = 4'b1000; din = 4'h1; cycle();
    load_en = 4'b0100; din = 4'h2; cycle();
    load_en = 4'b0010; din = 4'hA; cycle();
    load_en = 4'b0001; din = 4'hF; cycle();
    quiet(3'd7, 1'b0);
    cycle();
    cnt_e = 0; cnt_d = 0; cnt_b = 0; cnt_7 = 0; cnt_f = 0;
    for (int c = 0; c < 16; c++) begin
      cycle();
      case (an)
        4'hE: begin cnt_e++; chk("scan_d0_seg", seg, 7'h0E); end
        4'hD: begin cnt_d++; chk("scan_d1_seg", seg, 7'h08); end
        4'hB: begin cnt_b++; chk("scan_d2_seg", seg, 7'h24); end
        4'h7: begin cnt_7++; chk("scan_d3_seg", seg, 7'h79); end
        default: cnt_f++;
      endcase
    end
    chk("scan_cnt_d0", cnt_e, 3);
    chk("scan_cnt_d1", cnt_d, 3);
    chk("scan_cnt_d2", cnt_b, 3);
    chk("scan_cnt_d3", cnt_7, 3);
    chk("scan_cnt_dark", cnt_f, 4);

    // Leading-zero suppression with digits 0,0,5,0
    load_en = 4'b1101; din = 4'h0; cycle();
    load_en = 4'b0010; din = 4'h5; cycle();
    quiet(3'd7, 1'b1);
    cycle();
    cnt_a2 = 0; cnt_a3 = 0; cnt_d = 0; cnt_e = 0;
    for (int c = 0; c < 16; c++) begin
      cycle();
      if (!an[2]) cnt_a2++;
      if (!an[3]) cnt_a3++;
      if (an == 4'hD) begin cnt_d++; chk("lzs_d1_seg", seg, 7'h12); end
      if (an == 4'hE) begin cnt_e++; chk("lzs_d0_seg", seg, 7'h40); end
    end
    chk("lzs_an3_dark", cnt_a3, 0);
    chk("lzs_an2_dark", cnt_a2, 0);
    chk("lzs_d1_lit", cnt_d, 3);
    chk("lzs_d0_lit", cnt_e, 3);

    load_en = 4'b1111; din = 4'h0; cycle();
    quiet(3'd7, 1'b1);
    cnt_e = 0; cnt_lit = 0;
    for (int c = 0; c < 16; c++) begin
      cycle();
      if (an == 4'hE) cnt_e++;
      else if (an != 4'hF) cnt_lit++;
    end
    chk("lzs_zero_d0", cnt_e, 3);
    chk("lzs_zero_others", cnt_lit, 0);

    // Blanking and decimal point
    quiet(3'd7, 1'b0);
    blank_mask = 4'b0100; dp_mask = 4'b0001;
    cnt_a2 = 0; cnt_dp = 0;
    for (int c = 0; c < 16; c++) begin
      cycle();
      if (!an[2]) cnt_a2++;
      if (!dp) cnt_dp++;
    end
    chk("blank_an2", cnt_a2, 0);
    chk("dp_low_cnt", cnt_dp, 4);

    // Brightness duty over 64 clocks
    quiet(3'd3, 1'b0);
    cnt_lit = 0;
    for (int c = 0; c < 64; c++) begin cycle(); if (an != 4'hF) cnt_lit++; end
    chk("duty_b3", cnt_lit, 24);
    quiet(3'd0, 1'b0);
    cnt_lit = 0;
    for (int c = 0; c < 64; c++) begin cycle(); if (an != 4'hF) cnt_lit++; end
    chk("duty_b0", cnt_lit, 0);
    quiet(3'd7, 1'b0);
    cnt_lit = 0;
    for (int c = 0; c < 64; c++) begin cycle(); if (an != 4'hF) cnt_lit++; end
    chk("duty_b7", cnt_lit, 48);

    // Randomised traffic
    for (int c = 0; c < 400; c++) begin
      din     = 4'($urandom);
      load_en = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 15) == 0) begin
        dp_mask    = N'($urandom);
        blank_mask = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
        lzs        = 1'($urandom);
      end
      if ($urandom_range(0, 7) == 0) bright = 3'($urandom);
      cycle();
    end

    // Asynchronous reset while digit 2 is being scanned
    quiet(3'd7, 1'b0);
    load_en = 4'b1111; din = 4'h8; cycle();
    load_en = '0;
    for (int c = 0; c < 32 && m_idx != 2; c++) cycle();
    chk("find_idx2", m_idx, 2);
    cycle();
    #2 reset_n = 1'b0;
    #1;
    chk("async_an", an, 4'hF);
    chk("async_seg", seg, 7'h7F);
    chk("async_dp", dp, 1'b1);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    cycle();
    cycle();
    chk("post_rst_an", an, 4'hE);
    chk("post_rst_seg", seg, 7'h40);
    for (int c = 0; c < 20; c++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
